// File: rtl/ipml_reg_fifo_pkg.sv
// Shared helpers for the register FIFO: width calculation and parameter legality checks.
// Used by ipml_reg_fifo_v2_0_sync_fifo_256x32b (optional bypass: IPML_REG_FIFO_BYPASS_EN).
package ipml_reg_fifo_pkg;

  // Ceiling log2 for elaboration-time width calculation.
  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 32'sd1;
      end
    end
    return result;
  endfunction

  // Pointer width (AW) for a given depth.
  function automatic int addr_width(input int depth);
    return clog2(depth);
  endfunction

  // Level width (LW = AW + 1), wide enough to hold the value DEPTH itself.
  function automatic int level_width(input int depth);
    return clog2(depth) + 32'sd1;
  endfunction

  function automatic bit depth_legal(input int depth);
    return (depth >= 32'sd2) && ((depth & (depth - 32'sd1)) == 32'sd0);
  endfunction

  function automatic bit af_level_legal(input int af_level, input int depth);
    return (af_level >= 32'sd1) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/ipml_reg_fifo_v2_0_ptr_ctrl.sv
// Read/write pointers and occupancy register of the register FIFO.
// Flush clears pointers and level and takes priority over any handshake in the same cycle.
module ipml_reg_fifo_v2_0_ptr_ctrl
  import ipml_reg_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          write,
  input  logic                          read,
  output logic [addr_width(DEPTH)-1:0]  wptr,
  output logic [addr_width(DEPTH)-1:0]  rptr,
  output logic [level_width(DEPTH)-1:0] level
);

  localparam int AW = addr_width(DEPTH);
  localparam int LW = level_width(DEPTH);

  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [LW-1:0] LVL_ONE = LW'(1'b1);

  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [LW-1:0] level_r;

  // Pointer and level update; DEPTH is a power of two so pointers wrap by overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      level_r <= '0;
    end else if (flush) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      level_r <= '0;
    end else begin
      case ({write, read})
        2'b10: begin
          wptr_r  <= wptr_r + PTR_ONE;
          level_r <= level_r + LVL_ONE;
        end
        2'b01: begin
          rptr_r  <= rptr_r + PTR_ONE;
          level_r <= level_r - LVL_ONE;
        end
        2'b11: begin
          wptr_r <= wptr_r + PTR_ONE;
          rptr_r <= rptr_r + PTR_ONE;
        end
        default: begin
          wptr_r  <= wptr_r;
          rptr_r  <= rptr_r;
          level_r <= level_r;
        end
      endcase
    end
  end

  assign wptr  = wptr_r;
  assign rptr  = rptr_r;
  assign level = level_r;

endmodule

// File: rtl/ipml_reg_fifo_v2_0_sync_fifo_256x32b.sv
// Flop-based synchronous FIFO with valid/ready on both sides, occupancy and almost-full.
// Define IPML_REG_FIFO_BYPASS_EN for zero-latency pass-through while the FIFO is empty.
module ipml_reg_fifo_v2_0_sync_fifo_256x32b
  import ipml_reg_fifo_pkg::*;
#(
  parameter int W        = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          data_in_valid,
  input  logic [W-1:0]                  data_in,
  output logic                          data_in_ready,
  input  logic                          data_out_ready,
  output logic [W-1:0]                  data_out,
  output logic                          data_out_valid,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          almost_full
);

  localparam int AW = addr_width(DEPTH);
  localparam int LW = level_width(DEPTH);

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("ipml_reg_fifo: DEPTH must be a power of two and at least 2");
  end
  if (!af_level_legal(AF_LEVEL, DEPTH)) begin : g_bad_af_level
    $error("ipml_reg_fifo: AF_LEVEL must lie in 1..DEPTH");
  end

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wptr_s;
  logic [AW-1:0] rptr_s;
  logic [LW-1:0] level_s;
  logic          stored_valid_s;
  logic          pass_s;
  logic          write_s;
  logic          read_s;

  ipml_reg_fifo_v2_0_ptr_ctrl #(
    .DEPTH(DEPTH)
  ) u_ptr_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .write (write_s),
    .read  (read_s),
    .wptr  (wptr_s),
    .rptr  (rptr_s),
    .level (level_s)
  );

  // Handshakes and output mux; ready depends only on the level register.
  always_comb begin
    data_in_ready  = (level_s != LW'(DEPTH));
    stored_valid_s = (level_s != LW'(1'b0));
    data_out_valid = stored_valid_s;
    data_out       = mem_r[rptr_s];
    pass_s         = 1'b0;
`ifdef IPML_REG_FIFO_BYPASS_EN
    if ((level_s == LW'(1'b0)) && !flush) begin
      data_out_valid = data_in_valid;
      data_out       = data_in;
      pass_s         = data_in_valid & data_out_ready;
    end else begin
      pass_s         = 1'b0;
    end
`endif
    write_s = data_in_valid & data_in_ready & ~flush & ~pass_s;
    read_s  = stored_valid_s & data_out_ready & ~flush;
  end

  // Storage array; entries are only overwritten, never cleared on read or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (write_s) begin
      mem_r[wptr_s] <= data_in;
    end
  end

  assign level       = level_s;
  assign almost_full = (level_s >= LW'(AF_LEVEL));

endmodule

// File: tb/tb_ipml_reg_fifo_v2_0_sync_fifo_256x32b.sv
// Randomised self-checking bench for the register FIFO against a queue-based reference model.
module tb_ipml_reg_fifo_v2_0_sync_fifo_256x32b;

  localparam int W        = 8;
  localparam int DEPTH    = 4;
  localparam int AF_LEVEL = 3;
`ifdef IPML_REG_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         data_in_valid;
  logic [W-1:0] data_in;
  logic         data_in_ready;
  logic         data_out_ready;
  logic [W-1:0] data_out;
  logic         data_out_valid;
  logic [2:0]   level;
  logic         almost_full;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] q[$];

  always #5 clk = ~clk;

  ipml_reg_fifo_v2_0_sync_fifo_256x32b #(
    .W(W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .data_in_valid(data_in_valid), .data_in(data_in), .data_in_ready(data_in_ready),
    .data_out_ready(data_out_ready), .data_out(data_out), .data_out_valid(data_out_valid),
    .level(level), .almost_full(almost_full)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model mid-cycle, then advance the model.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    bit           exp_valid;
    logic [W-1:0] exp_data;
    bit           wr;
    bit           rd;
    bit           pass;
    data_in_valid  = v;
    data_in        = d;
    data_out_ready = r;
    flush          = f;
    #4;
    exp_valid = (q.size() != 0);
    exp_data  = exp_valid ? q[0] : '0;
    pass      = 1'b0;
    if (BYP && q.size() == 0 && !f) begin
      exp_valid = v;
      exp_data  = d;
      pass      = v && r;
    end
    check_eq("level", 32'(level), 32'(q.size()));
    check_eq("data_in_ready", 32'(data_in_ready), 32'(q.size() != DEPTH));
    check_eq("almost_full", 32'(almost_full), 32'(q.size() >= AF_LEVEL));
    check_eq("data_out_valid", 32'(data_out_valid), 32'(exp_valid));
    if (exp_valid) check_eq("data_out", 32'(data_out), 32'(exp_data));
    wr = v && (q.size() < DEPTH) && !pass;
    rd = (q.size() != 0) && r;
    @(posedge clk);
    #1;
    if (f) begin
      q.delete();
    end else begin
      if (rd) void'(q.pop_front());
      if (wr) q.push_back(d);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_level"}, 32'(level), 32'd0);
    check_eq({tag, "_in_ready"}, 32'(data_in_ready), 32'd1);
    check_eq({tag, "_out_valid"}, 32'(data_out_valid), 32'd0);
    check_eq({tag, "_data_out"}, 32'(data_out), 32'd0);
    check_eq({tag, "_almost_full"}, 32'(almost_full), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; data_in_valid = 1'b0; data_in = '0; data_out_ready = 1'b0;
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // fill with consumer stalled; fifth word must be refused
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    cyc(1'b1, 8'h44, 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b0, 1'b0);
    check_eq("fill_level", 32'(level), 32'd4);

    // drain in order
    repeat (5) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("drain_level", 32'(level), 32'd0);

    // streaming across pointer wrap
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // flush beats a simultaneous write and read
    repeat (3) cyc(1'b1, 8'hA1, 1'b0, 1'b0);
    cyc(1'b1, 8'hAA, 1'b1, 1'b1);
    check_eq("flush_level", 32'(level), 32'd0);
    repeat (2) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // asynchronous reset between edges
    cyc(1'b1, 8'hB1, 1'b0, 1'b0);
    cyc(1'b1, 8'hB2, 1'b0, 1'b0);
    data_in_valid = 1'b0; data_in = '0; data_out_ready = 1'b0; flush = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    q.delete();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef IPML_REG_FIFO_BYPASS_EN
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    check_eq("bypass_level_kept", 32'(level), 32'd0);
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    check_eq("bypass_stored", 32'(level), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
`endif

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ipml_reg_fifo_v2_0_sync_fifo_256x32b.md
Name: ipml_reg_fifo_v2_0_sync_fifo_256x32b

Overview:
Parametrised register-based synchronous FIFO with valid/ready handshakes on both sides. It generalises the 2-entry skid buffer to DEPTH entries and adds an occupancy count, an almost-full flag and a synchronous flush. It sits between IP-core pipeline stages where a shallow flop-based buffer is preferred over block RAM.

Parameters:
W, 8, data width in bits (>=1)
DEPTH, 4, number of entries; power of two, >=2
AF_LEVEL, DEPTH-1, almost_full asserts when level >= AF_LEVEL; legal range 1..DEPTH

Ports:
clk  input  1  single clock; all logic is rising-edge
rst_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous clear of FIFO contents
data_in_valid  input  1  producer has data
data_in  input  W  producer data
data_in_ready  output  1  FIFO can accept a word this cycle
data_out_ready  input  1  consumer accepts data
data_out  output  W  head-of-FIFO data
data_out_valid  output  1  head data valid
level  output  $clog2(DEPTH)+1  number of stored words
almost_full  output  1  level >= AF_LEVEL

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk. Reset values: wptr=0, rptr=0, level=0, all storage=0, data_in_ready=1, data_out_valid=0, data_out=0, almost_full=0.
- Pointers: AW=$clog2(DEPTH) bits; wrap naturally from DEPTH-1 to 0. level is AW+1 bits and is held in a register, not derived from pointers.
- write = data_in_valid & data_in_ready; read = data_out_valid & data_out_ready.
- data_in_ready = (level != DEPTH). It is registered-derived, with no combinational path from data_out_ready. When full, writes stall even if a read occurs in the same cycle.
- data_out_valid = (level != 0). data_out = mem[rptr], first-word fall-through. A word written in cycle N is visible at the output in cycle N+1.
- Write only: mem[wptr] <= data_in, wptr++, level++.
- Read only: rptr++, level--. Storage is not cleared on read.
- Simultaneous read and write: both pointers advance and level is unchanged. Legal at any level from 1 to DEPTH-1.
- flush=1: wptr, rptr and level go to 0 next cycle. flush overrides any write or read in that cycle. Storage keeps its contents. Outputs follow the new level.
- almost_full is registered-derived: it equals (level >= AF_LEVEL) combinationally from the level register.
- Reset mid-operation: all state returns to reset values immediately; in-flight words are lost.
- Overflow and underflow are impossible by construction, because the handshakes gate both write and read.

Optional Feature:
Macro IPML_REG_FIFO_BYPASS_EN.
- Defined: zero-latency bypass when empty.
  - If level==0 and flush==0, data_out_valid = data_in_valid and data_out = data_in, both combinational.
  - If level==0, data_in_valid=1, data_out_ready=1 and flush==0, the word passes straight through. Nothing is stored and the pointers and level are unchanged.
  - If level==0, data_in_valid=1 and data_out_ready=0, the word is stored normally.
  - With level>0, behaviour is identical to the non-bypass build.
- Undefined: no input-to-output combinational path; minimum latency is 1 cycle.

Decomposition:
- Shared package ipml_reg_fifo_pkg holds:
  - a clog2 constant function;
  - localparam helpers AW and LW=AW+1;
  - the parameter legality checks (DEPTH a power of two, AF_LEVEL in range), reported as elaboration errors.
- One sub-module, ipml_reg_fifo_v2_0_ptr_ctrl, holds the wptr, rptr and level registers, the wrap logic and flush handling. The top level keeps the storage array, output mux and optional bypass.

Test Plan:
- Fill: W=8, DEPTH=4, AF_LEVEL=3, data_out_ready=0; write 0x11,0x22,0x33,0x44. Expect level 1,2,3,4; almost_full rises with level=3; data_in_ready=0 at level=4; a 5th word 0x55 is not accepted.
- Drain and order: from full, hold data_out_ready=1. Expect outputs 0x11,0x22,0x33,0x44 on consecutive cycles, then data_out_valid=0 and level=0.
- Streaming wrap: valid=ready=1 continuously for 10 words 0x00..0x09. Expect level steady at 1 after the first cycle (non-bypass), output in order, and pointers wrapping past 3 without loss.
- Flush priority: at level=3, assert flush together with a write of 0xAA and a read. Next cycle expect level=0, data_out_valid=0, data_in_ready=1; 0xAA is never output.
- Async reset mid-stream: pull rst_n low between clock edges at level=2. Expect outputs to reset values immediately; after release, write 0x5A and see it at data_out one cycle later.
- Bypass (IPML_REG_FIFO_BYPASS_EN): empty FIFO, data_in=0x77, valid=ready=1. Expect data_out=0x77 and data_out_valid=1 in the same cycle, level stays 0. With ready=0, expect level to become 1.
